// File: rtl/joy_db15_scan_ctrl.sv
// rtl/joy_db15_scan_ctrl.sv - DB15 splitter serial-chain scanner with two-scan glitch filter
module joy_db15_scan_ctrl #(
  parameter int CLK_DIV  = 4,
  parameter int NBITS    = 24,
  parameter int SCAN_GAP = 4096,
  parameter bit FILTER   = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  output logic             joy_clk,
  output logic             joy_load,
  input  logic             joy_data,
  output logic [NBITS-1:0] frame,
  output logic             frame_valid,
  input  logic             frame_ack,
  output logic             scan_busy,
  output logic [7:0]       glitch_cnt
);

  localparam int CW = $clog2(SCAN_GAP + 2*CLK_DIV + 1);
  localparam int BW = $clog2(NBITS + 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BIT_END  = CW'(2*CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_END  = CW'(SCAN_GAP - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(NBITS - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, CHECK, GAP} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [BW-1:0]    bit_idx;
  logic [NBITS-1:0] shreg;
  logic [NBITS-1:0] prev;
  logic [1:0]       sync;
  logic             match;

  assign match = (FILTER == 1'b0) || (shreg == prev);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '1;
      prev        <= '1;
      sync        <= 2'b11;
      joy_clk     <= 1'b0;
      joy_load    <= 1'b1;
      frame       <= '0;
      frame_valid <= 1'b0;
      scan_busy   <= 1'b0;
      glitch_cnt  <= '0;
    end else begin
      sync <= {sync[0], joy_data};
      // A publish in CHECK below overrides this clear, so a coincident ack keeps valid high.
      if (frame_valid && frame_ack)
        frame_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (enable) begin
            state     <= LOAD;
            joy_load  <= 1'b0;
            scan_busy <= 1'b1;
            cnt       <= '0;
          end
        end
        LOAD: begin
          if (cnt == BIT_END) begin
            joy_load <= 1'b1;
            state    <= SHIFT;
            cnt      <= '0;
            bit_idx  <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (cnt == HALF_END) begin
            joy_clk                  <= 1'b1;
            shreg[LAST_BIT - bit_idx] <= sync[1];
          end
          if (cnt == BIT_END) begin
            joy_clk <= 1'b0;
            cnt     <= '0;
            if (bit_idx == LAST_BIT)
              state <= CHECK;
            else
              bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CHECK: begin
          prev <= shreg;
          if (match) begin
            frame       <= ~shreg;
            frame_valid <= 1'b1;
          end else if (glitch_cnt != 8'hFF) begin
            glitch_cnt <= glitch_cnt + 1'b1;
          end
          state     <= GAP;
          scan_busy <= 1'b0;
          cnt       <= '0;
        end
        GAP: begin
          if (cnt == GAP_END) begin
            cnt <= '0;
            if (enable) begin
              state     <= LOAD;
              joy_load  <= 1'b0;
              scan_busy <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_joy_db15_scan_ctrl.sv
// tb/tb_joy_db15_scan_ctrl.sv - scoreboard bench for joy_db15_scan_ctrl
module tb_joy_db15_scan_ctrl;
  localparam int NB  = 24;
  localparam int GAP = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          frame_ack = 1'b0;
  logic          joy_data;
  logic          joy_clk, joy_load, frame_valid, scan_busy;
  logic [NB-1:0] frame;
  logic [7:0]    glitch_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  joy_db15_scan_ctrl #(.CLK_DIV(4), .NBITS(NB), .SCAN_GAP(GAP), .FILTER(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .joy_clk(joy_clk), .joy_load(joy_load), .joy_data(joy_data),
    .frame(frame), .frame_valid(frame_valid), .frame_ack(frame_ack),
    .scan_busy(scan_busy), .glitch_cnt(glitch_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // 74HC165-style chain: parallel load while joy_load low, shift on joy_clk rise
  logic [NB-1:0] cur_pat = '1;
  logic [NB-1:0] chain = '1;
  logic          jclk_d = 1'b0;
  always @(posedge clk) begin
    jclk_d <= joy_clk;
    if (!joy_load) chain <= cur_pat;
    else if (joy_clk && !jclk_d) chain <= {chain[NB-2:0], 1'b1};
  end
  assign joy_data = chain[NB-1];

  typedef struct {
    logic          match;
    logic [NB-1:0] frame;
    logic [7:0]    glitch;
  } exp_t;

  exp_t          sb[$];
  logic [NB-1:0] pat_q[$];
  exp_t          e;
  logic [NB-1:0] p;
  logic [NB-1:0] prev_m = '1;
  logic [NB-1:0] frame_m = '0;
  logic [7:0]    glitch_m = '0;
  logic          valid_m = 1'b0, pub = 1'b0, ack_q = 1'b0;
  logic          load_q = 1'b1, jclk_q = 1'b0, busy_q = 1'b0, in_scan = 1'b0, in_check = 1'b0;
  int            lat = 0, low_cnt = 0, rises = 0, scans_done = 0, starts = 0;

  always @(posedge clk) ack_q <= frame_ack;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      prev_m = '1; frame_m = '0; glitch_m = '0; valid_m = 1'b0;
      load_q = 1'b1; jclk_q = 1'b0; busy_q = 1'b0; in_scan = 1'b0; in_check = 1'b0;
    end else begin
      pub = 1'b0;
      if (in_scan) lat++;
      if (!joy_load && load_q) begin
        in_scan = 1'b1; lat = 0; low_cnt = 0; rises = 0; starts++;
        p = (pat_q.size() > 0) ? pat_q.pop_front() : cur_pat;
        cur_pat = p;
        e.match = (p == prev_m);
        prev_m = p;
        if (e.match) frame_m = ~p;
        else if (glitch_m != 8'hFF) glitch_m = glitch_m + 8'd1;
        e.frame = frame_m;
        e.glitch = glitch_m;
        sb.push_back(e);
      end
      if (!joy_load) low_cnt++;
      if (joy_clk && !jclk_q) rises++;
      in_check = in_scan && !joy_clk && jclk_q && (rises == NB);
      if (busy_q && !scan_busy) begin
        scans_done++;
        in_scan = 1'b0;
        check("latency", lat, 201);
        check("load_low_cycles", low_cnt, 8);
        check("clk_rises", rises, NB);
        if (sb.size() == 0) begin
          check("sb_underflow", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          check("frame", frame, e.frame);
          check("glitch_cnt", glitch_cnt, e.glitch);
          if (e.match) begin
            valid_m = 1'b1;
            pub = 1'b1;
          end
        end
      end
      if (!pub && ack_q) valid_m = 1'b0;
      check("frame_valid", frame_valid, valid_m);
      load_q = joy_load; jclk_q = joy_clk; busy_q = scan_busy;
    end
  end

  task automatic wait_scans(input int n);
    int target;
    int budget;
    target = scans_done + n;
    budget = n * 400 + 200;
    while (scans_done < target && budget > 0) begin
      @(negedge clk); #1;
      budget--;
    end
    if (scans_done < target) check("scan_timeout", scans_done, target);
  endtask

  task automatic wait_rises(input int n);
    int budget;
    budget = 1000;
    while (!(in_scan && rises >= n) && budget > 0) begin
      @(negedge clk); #1;
      budget--;
    end
    if (budget == 0) check("rise_timeout", rises, n);
  endtask

  task automatic wait_check_cycle();
    int budget;
    budget = 1000;
    while (!in_check && budget > 0) begin
      @(negedge clk); #1;
      budget--;
    end
    if (budget == 0) check("check_timeout", in_check, 1);
  endtask

  task automatic pulse_ack();
    frame_ack = 1'b1;
    @(negedge clk); #1;
    frame_ack = 1'b0;
  endtask

  int st;

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("rst_joy_clk", joy_clk, 0);
    check("rst_joy_load", joy_load, 1);
    check("rst_frame", frame, 0);
    check("rst_valid", frame_valid, 0);
    check("rst_busy", scan_busy, 0);
    check("rst_glitch", glitch_cnt, 0);
    rst_n = 1'b1;
    enable = 1'b1;

    // all-ones chain matches the reset prev register on the very first scan
    wait_scans(1);
    check("t1_frame", frame, 24'h000000);
    check("t1_valid", frame_valid, 1);
    pulse_ack();
    check("t1_ack_clear", frame_valid, 0);

    pat_q.push_back(24'hA5F00F);
    pat_q.push_back(24'hA5F00F);
    wait_scans(1);
    check("t2_reject_glitch", glitch_cnt, 1);
    check("t2_reject_valid", frame_valid, 0);
    wait_scans(1);
    check("t2_frame", frame, 24'h5A0FF0);

    pat_q.push_back(24'hA5F00E);
    pat_q.push_back(24'hA5F00F);
    pat_q.push_back(24'hA5F00F);
    wait_scans(2);
    check("t3_glitch", glitch_cnt, 3);
    check("t3_frame_hold", frame, 24'h5A0FF0);
    wait_scans(1);
    check("t3_frame", frame, 24'h5A0FF0);

    pat_q.push_back(24'h111111); pat_q.push_back(24'h111111);
    pat_q.push_back(24'h222222); pat_q.push_back(24'h222222);
    pat_q.push_back(24'h333333); pat_q.push_back(24'h333333);
    wait_scans(6);
    check("t4_latest_frame", frame, 24'hCCCCCC);
    check("t4_valid_held", frame_valid, 1);
    pat_q.push_back(24'h444444); pat_q.push_back(24'h444444);
    wait_scans(1);
    wait_check_cycle();
    frame_ack = 1'b1;
    @(negedge clk); #1;
    frame_ack = 1'b0;
    check("t4_ack_publish_valid", frame_valid, 1);
    check("t4_ack_publish_frame", frame, 24'hBBBBBB);
    pulse_ack();
    check("t4_ack_alone", frame_valid, 0);

    wait_rises(10);
    enable = 1'b0;
    st = starts;
    wait_scans(1);
    check("t5_frame", frame, 24'hBBBBBB);
    repeat (GAP + 10) @(negedge clk);
    #1;
    check("t5_idle_load", joy_load, 1);
    check("t5_idle_clk", joy_clk, 0);
    check("t5_idle_busy", scan_busy, 0);
    check("t5_no_restart", starts, st);

    enable = 1'b1;
    wait_rises(5);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_joy_clk", joy_clk, 0);
    check("t5_rst_joy_load", joy_load, 1);
    check("t5_rst_frame", frame, 0);
    check("t5_rst_valid", frame_valid, 0);
    check("t5_rst_busy", scan_busy, 0);
    check("t5_rst_glitch", glitch_cnt, 0);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    wait_scans(2);
    check("t5_post_glitch", glitch_cnt, 1);
    check("t5_post_frame", frame, 24'hBBBBBB);

    for (int i = 0; i < 260; i++)
      pat_q.push_back((i % 2 == 0) ? 24'h0F0F0F : 24'hF0F0F0);
    wait_scans(260);
    check("t6_glitch_sat", glitch_cnt, 255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
